// File: rtl/memory_bus_pkg.sv
// Shared constants and types for the 8008 memory bus controller: memory map,
// FSM state encoding and target-select codes.
package memory_bus_pkg;

   localparam logic [5:0] RAM_PAGE_DEF    = 6'h20;
   localparam logic [5:0] PERIPH_PAGE_DEF = 6'h24;
   localparam logic [5:0] ROM_TOP_DEF     = 6'h0F;
   localparam int         WAIT_CYCLES_DEF = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } bus_state_t;

   typedef enum logic [1:0] {
      SEL_ROM    = 2'd0,
      SEL_RAM    = 2'd1,
      SEL_PERIPH = 2'd2,
      SEL_NONE   = 2'd3
   } target_sel_t;

   // What must survive past the accept cycle to finish the access.
   typedef struct packed {
      logic        write;
      target_sel_t sel;
   } bus_req_t;

   function automatic logic [5:0] page_of(input logic [13:0] addr);
      return addr[13:8];
   endfunction

endpackage

// File: rtl/memory_bus_if.sv
// Core-side request/response bundle of the memory bus.
interface memory_bus_if;

   logic [13:0] address;
   logic [7:0]  data_in;
   logic        write_enable;
   logic        bus_enable;
   logic [7:0]  data_out;
   logic        bus_ready;
   logic        busy;
   logic        bus_error;

   modport master (
      output address, data_in, write_enable, bus_enable,
      input  data_out, bus_ready, busy, bus_error
   );

   modport slave (
      input  address, data_in, write_enable, bus_enable,
      output data_out, bus_ready, busy, bus_error
   );

endinterface

// File: rtl/memory_bus_address_decode.sv
// Combinational page decode: address[13:8] -> target select.
// ROM wins over RAM, RAM over peripherals, so overlapping maps stay deterministic.
module address_decode
   import memory_bus_pkg::*;
#(
   parameter logic [5:0] RAM_PAGE    = RAM_PAGE_DEF,
   parameter logic [5:0] PERIPH_PAGE = PERIPH_PAGE_DEF,
   parameter logic [5:0] ROM_TOP     = ROM_TOP_DEF
) (
   input  logic [5:0]  page,
   output target_sel_t sel
);

   always_comb begin
      sel = SEL_NONE;
      if (page <= ROM_TOP)          sel = SEL_ROM;
      else if (page == RAM_PAGE)    sel = SEL_RAM;
      else if (page == PERIPH_PAGE) sel = SEL_PERIPH;
   end

endmodule

// File: rtl/memory_bus.sv
// Single-master bus controller: latches one core request, strobes the decoded
// target, and returns registered read data with a one-cycle bus_ready pulse.
module memory_bus
   import memory_bus_pkg::*;
#(
   parameter logic [5:0] RAM_PAGE    = RAM_PAGE_DEF,
   parameter logic [5:0] PERIPH_PAGE = PERIPH_PAGE_DEF,
   parameter logic [5:0] ROM_TOP     = ROM_TOP_DEF,
   parameter int         WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         reset,
   memory_bus_if.slave  bus,
   output logic [11:0]  rom_address,
   input  logic [7:0]   rom_data_out,
   output logic [8:0]   ram_address,
   output logic [7:0]   ram_data_in,
   input  logic [7:0]   ram_data_out,
   output logic         ram_write_enable,
   output logic [7:0]   periph_address,
   input  logic [7:0]   periph_data_in,
   output logic [7:0]   periph_data_out,
   output logic         periph_write,
   output logic         periph_read
);

   localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

   bus_state_t  state;
   bus_req_t    req;
   target_sel_t dec_sel;
   logic [5:0]  req_page;
   logic [2:0]  wait_cnt;
   logic        last_cycle;
   logic [7:0]  rd_mux;
   logic [7:0]  data_out_q;
   logic        ready_q, busy_q, error_q;
   logic        ram_we_q, periph_wr_q, periph_rd_q;

   assign req_page = page_of(bus.address);

   address_decode #(
      .RAM_PAGE    (RAM_PAGE),
      .PERIPH_PAGE (PERIPH_PAGE),
      .ROM_TOP     (ROM_TOP)
   ) u_decode (
      .page (req_page),
      .sel  (dec_sel)
   );

   // A synchronous ROM only has data one cycle after ACCESS, so ROM reads
   // need WAIT_CYCLES >= 1; RAM and peripheral reads are combinational.
   always_comb begin
      rd_mux = 8'h00;
      case (req.sel)
         SEL_ROM:    rd_mux = rom_data_out;
         SEL_RAM:    rd_mux = ram_data_out;
         SEL_PERIPH: rd_mux = periph_data_in;
         default:    rd_mux = 8'h00;
      endcase
   end

   assign last_cycle = (state == ST_ACCESS && WAIT_CYCLES == 0) ||
                       (state == ST_WAIT && wait_cnt == 3'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         req             <= '{write: 1'b0, sel: SEL_NONE};
         wait_cnt        <= 3'd0;
         data_out_q      <= 8'h00;
         ready_q         <= 1'b0;
         busy_q          <= 1'b0;
         error_q         <= 1'b0;
         ram_we_q        <= 1'b0;
         periph_wr_q     <= 1'b0;
         periph_rd_q     <= 1'b0;
         rom_address     <= 12'h000;
         ram_address     <= 9'h000;
         ram_data_in     <= 8'h00;
         periph_address  <= 8'h00;
         periph_data_out <= 8'h00;
      end else begin
         ram_we_q    <= 1'b0;
         periph_wr_q <= 1'b0;
         periph_rd_q <= 1'b0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.bus_enable) begin
                  req             <= '{write: bus.write_enable, sel: dec_sel};
                  rom_address     <= bus.address[11:0];
                  ram_address     <= {1'b0, bus.address[7:0]};
                  periph_address  <= bus.address[7:0];
                  ram_data_in     <= bus.data_in;
                  periph_data_out <= bus.data_in;
                  // Strobes land in the ACCESS cycle and clear themselves after one cycle.
                  ram_we_q        <= bus.write_enable && (dec_sel == SEL_RAM);
                  periph_wr_q     <= bus.write_enable && (dec_sel == SEL_PERIPH);
                  periph_rd_q     <= !bus.write_enable && (dec_sel == SEL_PERIPH);
                  busy_q          <= 1'b1;
                  state           <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               wait_cnt <= WAIT_LOAD;
               state    <= last_cycle ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - 3'd1;
               if (last_cycle) state <= ST_DONE;
            end
            ST_DONE: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         if (last_cycle) begin
            ready_q <= 1'b1;
            error_q <= (req.sel == SEL_NONE);
            if (!req.write) data_out_q <= rd_mux;
         end
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.bus_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.bus_error = error_q;

   // Gating with reset kills a strobe already on the wire when reset lands mid-access.
   assign ram_write_enable = ram_we_q & ~reset;
   assign periph_write     = periph_wr_q & ~reset;
   assign periph_read      = periph_rd_q & ~reset;

endmodule

// File: tb/tb_memory_bus.sv
// Bench for memory_bus: a WAIT_CYCLES=0 and a WAIT_CYCLES=3 instance, each with
// its own sync ROM / comb RAM / peripheral models, checked against a reference.
module tb_memory_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_a, we_a, en_a;
  logic [1:0][13:0] address_a;
  logic [1:0][7:0]  data_in_a, dout_a;
  logic [1:0]       rdy_a, busy_a, err_a;
  logic [1:0][11:0] rom_addr_a;
  logic [1:0][8:0]  ram_addr_a;
  logic [1:0][7:0]  ram_din_a, p_addr_a, p_dout_a;
  logic [1:0]       ram_we_a, p_wr_a, p_rd_a;

  logic [7:0] rom_mem [4096];
  logic [7:0] ref_ram [2][256];
  logic [7:0] ref_dout [2];
  int total = 0;
  int bad = 0;

  function automatic logic [7:0] pfunc(input logic [7:0] a);
    return a ^ 8'hC3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    memory_bus_if bus_i();
    logic [7:0] rom_q;
    logic [7:0] ram_q;
    logic [7:0] p_din;
    logic [7:0] mem [256] = '{default: 8'h00};

    assign bus_i.address      = address_a[g];
    assign bus_i.data_in      = data_in_a[g];
    assign bus_i.write_enable = we_a[g];
    assign bus_i.bus_enable   = en_a[g];
    assign dout_a[g] = bus_i.data_out;
    assign rdy_a[g]  = bus_i.bus_ready;
    assign busy_a[g] = bus_i.busy;
    assign err_a[g]  = bus_i.bus_error;
    assign ram_q = mem[ram_addr_a[g][7:0]];
    assign p_din = pfunc(p_addr_a[g]);

    always @(posedge clk) begin
      rom_q <= rom_mem[rom_addr_a[g]];
      if (ram_we_a[g]) mem[ram_addr_a[g][7:0]] <= ram_din_a[g];
    end

    memory_bus #(.WAIT_CYCLES(g == 0 ? 0 : 3)) u_dut (
      .clk(clk), .reset(rst_a[g]), .bus(bus_i),
      .rom_address(rom_addr_a[g]), .rom_data_out(rom_q),
      .ram_address(ram_addr_a[g]), .ram_data_in(ram_din_a[g]),
      .ram_data_out(ram_q), .ram_write_enable(ram_we_a[g]),
      .periph_address(p_addr_a[g]), .periph_data_in(p_din),
      .periph_data_out(p_dout_a[g]), .periph_write(p_wr_a[g]),
      .periph_read(p_rd_a[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory map as plain address ranges: 0=ROM 1=RAM 2=periph 3=unmapped.
  function automatic int region(input logic [13:0] a);
    if (a < 14'h1000) return 0;
    if (a >= 14'h2000 && a <= 14'h20FF) return 1;
    if (a >= 14'h2400 && a <= 14'h24FF) return 2;
    return 3;
  endfunction

  task automatic predict(input int i, input logic [13:0] a, input logic we,
                         output logic [7:0] xd, output logic xe, output logic [2:0] xm);
    int rg;
    rg = region(a);
    xe = (rg == 3);
    xd = ref_dout[i];
    xm = 3'b000;
    if (we) begin
      if (rg == 1) xm = 3'b100;
      if (rg == 2) xm = 3'b010;
    end else begin
      case (rg)
        0: xd = rom_mem[a[11:0]];
        1: xd = ref_ram[i][a[7:0]];
        2: begin xd = pfunc(a[7:0]); xm = 3'b001; end
        default: xd = 8'h00;
      endcase
    end
  endtask

  // One access; x_mask = {ram_write_enable, periph_write, periph_read} pulse expected.
  task automatic do_txn(input int i, input logic [13:0] a, input logic we, input logic [7:0] d,
                        input logic glitch, input int tail, input logic [7:0] x_dout,
                        input logic x_err, input logic [2:0] x_mask, input string tag);
    int lat, n_rdy, rdy_at, n_rwe, n_pw, n_pr;
    logic err_s;
    logic [7:0] dout_s;
    lat = (i == 0) ? 2 : 5;
    n_rdy = 0; rdy_at = -1; n_rwe = 0; n_pw = 0; n_pr = 0;
    err_s = 1'b0; dout_s = 8'h00;
    @(negedge clk);
    address_a[i] = a; data_in_a[i] = d; we_a[i] = we; en_a[i] = 1'b1;
    for (int k = 1; k <= lat + tail; k++) begin
      @(negedge clk);
      if (k == 1 && glitch) begin
        address_a[i] = 14'h2010; we_a[i] = 1'b1; data_in_a[i] = 8'hEE;
      end else en_a[i] = 1'b0;
      if (rdy_a[i]) begin
        n_rdy++;
        if (rdy_at < 0) rdy_at = k;
        err_s = err_a[i];
        dout_s = dout_a[i];
      end
      if (ram_we_a[i]) begin
        n_rwe++;
        chk({tag, "/ram_addr"}, int'(ram_addr_a[i]), int'({1'b0, a[7:0]}));
        chk({tag, "/ram_din"}, int'(ram_din_a[i]), int'(d));
      end
      if (p_wr_a[i]) begin
        n_pw++;
        chk({tag, "/p_waddr"}, int'(p_addr_a[i]), int'(a[7:0]));
        chk({tag, "/p_dout"}, int'(p_dout_a[i]), int'(d));
      end
      if (p_rd_a[i]) begin
        n_pr++;
        chk({tag, "/p_raddr"}, int'(p_addr_a[i]), int'(a[7:0]));
      end
      if (k == 1 || k == lat) chk({tag, "/busy"}, int'(busy_a[i]), 1);
      if (k == lat + 1) chk({tag, "/busy_drop"}, int'(busy_a[i]), 0);
    end
    en_a[i] = 1'b0;
    chk({tag, "/rdy_count"}, n_rdy, 1);
    chk({tag, "/rdy_latency"}, rdy_at, lat);
    chk({tag, "/err"}, int'(err_s), int'(x_err));
    chk({tag, "/dout"}, int'(dout_s), int'(x_dout));
    chk({tag, "/strobes"}, n_rwe * 100 + n_pw * 10 + n_pr,
        int'(x_mask[2]) * 100 + int'(x_mask[1]) * 10 + int'(x_mask[0]));
    if (tail > 0) chk({tag, "/dout_hold"}, int'(dout_a[i]), int'(x_dout));
    if (!we) ref_dout[i] = x_dout;
    if (we && region(a) == 1) ref_ram[i][a[7:0]] = d;
  endtask

  task automatic run_model(input int i, input logic [13:0] a, input logic we, input logic [7:0] d,
                           input logic glitch, input int tail, input string tag);
    logic [7:0] xd;
    logic xe;
    logic [2:0] xm;
    predict(i, a, we, xd, xe, xm);
    do_txn(i, a, we, d, glitch, tail, xd, xe, xm, tag);
  endtask

  typedef struct {
    int          inst;
    logic [13:0] a;
    logic        we;
    logic [7:0]  d;
    logic        glitch;
    logic [7:0]  x_dout;
    logic        x_err;
    logic [2:0]  x_mask;
  } vec_t;

  vec_t vt [13];

  initial begin
    int n;
    logic [13:0] a;
    logic we;
    rst_a = 2'b11; en_a = '0; we_a = '0; address_a = '0; data_in_a = '0;
    for (int k = 0; k < 4096; k++) rom_mem[k] = 8'($urandom);
    rom_mem[12'h123] = 8'h7E;
    rom_mem[12'hFFF] = 8'hC9;
    for (int i = 0; i < 2; i++) begin
      ref_dout[i] = 8'h00;
      for (int k = 0; k < 256; k++) ref_ram[i][k] = 8'h00;
    end

    vt[0]  = '{0, 14'h2005, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 3'b100};
    vt[1]  = '{0, 14'h2005, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 3'b000};
    vt[2]  = '{0, 14'h3000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'b000};
    vt[3]  = '{0, 14'h3000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 3'b000};
    vt[4]  = '{0, 14'h2410, 1'b0, 8'h00, 1'b0, 8'hD3, 1'b0, 3'b001};
    vt[5]  = '{0, 14'h0040, 1'b1, 8'h55, 1'b0, 8'hD3, 1'b0, 3'b000};
    vt[6]  = '{0, 14'h24FF, 1'b1, 8'h3C, 1'b0, 8'hD3, 1'b0, 3'b010};
    vt[7]  = '{0, 14'h20FF, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'b000};
    vt[8]  = '{0, 14'h2010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'b000};
    vt[9]  = '{0, 14'h2100, 1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 3'b000};
    vt[10] = '{1, 14'h0123, 1'b0, 8'h00, 1'b0, 8'h7E, 1'b0, 3'b000};
    vt[11] = '{1, 14'h0FFF, 1'b0, 8'h00, 1'b1, 8'hC9, 1'b0, 3'b000};
    vt[12] = '{1, 14'h1000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'b000};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset%0d/dout", i), int'(dout_a[i]), 0);
      chk($sformatf("reset%0d/flags", i),
          int'({rdy_a[i], busy_a[i], err_a[i], ram_we_a[i], p_wr_a[i], p_rd_a[i]}), 0);
      chk($sformatf("reset%0d/addr", i),
          int'(|{rom_addr_a[i], ram_addr_a[i], p_addr_a[i], ram_din_a[i], p_dout_a[i]}), 0);
    end
    rst_a = 2'b00;

    for (int v = 0; v < 13; v++)
      do_txn(vt[v].inst, vt[v].a, vt[v].we, vt[v].d, vt[v].glitch, 2,
             vt[v].x_dout, vt[v].x_err, vt[v].x_mask, $sformatf("vec%0d", v));

    // Back-to-back: each request raised in the cycle right after the previous DONE.
    run_model(0, 14'h2040, 1'b1, 8'h5A, 1'b0, 0, "b2b_w");
    run_model(0, 14'h2040, 1'b0, 8'h00, 1'b0, 0, "b2b_r");
    run_model(0, 14'h2410, 1'b0, 8'h00, 1'b0, 0, "b2b_p");
    run_model(1, 14'h2040, 1'b1, 8'h6B, 1'b0, 0, "b2b_w3");
    run_model(1, 14'h2040, 1'b0, 8'h00, 1'b0, 2, "b2b_r3");

    // Reset landing in the ACCESS cycle of a RAM write.
    run_model(0, 14'h2005, 1'b0, 8'h00, 1'b0, 1, "pre_rst");
    @(negedge clk);
    address_a[0] = 14'h2030; data_in_a[0] = 8'h77; we_a[0] = 1'b1; en_a[0] = 1'b1;
    @(negedge clk);
    en_a[0] = 1'b0;
    chk("midrst/busy_pre", int'(busy_a[0]), 1);
    rst_a[0] = 1'b1;
    #1;
    chk("midrst/ram_we", int'(ram_we_a[0]), 0);
    @(negedge clk);
    rst_a[0] = 1'b0;
    chk("midrst/busy", int'(busy_a[0]), 0);
    chk("midrst/dout", int'(dout_a[0]), 0);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(rdy_a[0]) + int'(ram_we_a[0]);
    end
    chk("midrst/no_ready", n, 0);
    ref_dout[0] = 8'h00;
    run_model(0, 14'h2030, 1'b0, 8'h00, 1'b0, 2, "post_rst");

    for (int i = 0; i < 2; i++) begin
      for (int t = 0; t < 50; t++) begin
        case ($urandom_range(0, 3))
          0: a = 14'($urandom_range(0, 16'h0FFF));
          1: a = 14'h2000 | 14'($urandom_range(0, 255));
          2: a = 14'h2400 | 14'($urandom_range(0, 255));
          default:
            case ($urandom_range(0, 2))
              0: a = 14'($urandom_range(16'h1000, 16'h1FFF));
              1: a = 14'($urandom_range(16'h2100, 16'h23FF));
              default: a = 14'($urandom_range(16'h2500, 16'h3FFF));
            endcase
        endcase
        we = 1'($urandom_range(0, 1));
        if (i == 0 && region(a) == 0) we = 1'b1;
        run_model(i, a, we, 8'($urandom), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 2)), $sformatf("rnd%0d_%0d", i, t));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
